// File: rtl/led_trail_pwm_if.sv
// Pattern-in / LED-out bundle between the rotator stage and the trail PWM block.
// master drives the pattern and observes the LED drive; slave is the PWM block.
interface led_trail_pwm_if #(
  parameter int N = 4
);
  logic [N-1:0] pat_in;
  logic [N-1:0] led_out;
  logic         frame_tick;

  modport master (output pat_in, input led_out, input frame_tick);
  modport slave  (input pat_in, output led_out, output frame_tick);
endinterface

// File: rtl/led_trail_pwm.sv
// LED trail dimmer: lit channels jump to full brightness, then fade by DECAY_STEP per PWM frame.
// Optional macro LED_TRAIL_GAMMA_EN squares the brightness level before PWM compare.
module led_trail_pwm #(
  parameter int N          = 4,
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 32
) (
  input  logic            clk,
  input  logic            rst,
  led_trail_pwm_if.slave  bus
);

  localparam logic [PWM_BITS-1:0] LVL_MAX = '1;
  localparam logic [PWM_BITS-1:0] STEP    = PWM_BITS'(DECAY_STEP);

  logic [PWM_BITS-1:0]        pwm_cnt_q, pwm_cnt_d;
  logic [N-1:0]               pat_q;
  logic [N-1:0]               hit_q, hit_d;
  logic [N-1:0][PWM_BITS-1:0] level_q, level_d;
  logic [N-1:0][PWM_BITS-1:0] duty;
  logic [N-1:0]               led_out_q, led_out_d;
  logic                       frame_tick_q;
  logic                       boundary;

  assign boundary  = (pwm_cnt_q == LVL_MAX);
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

  // A hit in the boundary cycle itself is seen through pat_q, so clearing hit loses nothing.
  always_comb begin
    hit_d   = boundary ? '0 : (hit_q | pat_q);
    level_d = level_q;
    if (boundary) begin
      for (int i = 0; i < N; i++) begin
        if (hit_q[i] | pat_q[i]) begin
          level_d[i] = LVL_MAX;
        end else if (level_q[i] > STEP) begin
          level_d[i] = level_q[i] - STEP;
        end else begin
          level_d[i] = '0;
        end
      end
    end
  end

`ifdef LED_TRAIL_GAMMA_EN
  logic [N-1:0][2*PWM_BITS-1:0] level_sq;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      level_sq[i] = {{PWM_BITS{1'b0}}, level_q[i]} * {{PWM_BITS{1'b0}}, level_q[i]};
      duty[i]     = level_sq[i][2*PWM_BITS-1:PWM_BITS];
    end
  end
`else
  assign duty = level_q;
`endif

  always_comb begin
    for (int i = 0; i < N; i++) begin
      led_out_d[i] = (pwm_cnt_q < duty[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q    <= '0;
      pat_q        <= '0;
      hit_q        <= '0;
      level_q      <= '0;
      led_out_q    <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      pwm_cnt_q    <= pwm_cnt_d;
      pat_q        <= bus.pat_in;
      hit_q        <= hit_d;
      level_q      <= level_d;
      led_out_q    <= led_out_d;
      frame_tick_q <= boundary;
    end
  end

  assign bus.led_out    = led_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: frame-window brightness tables, a decay pulse, a mid-frame reset,
// then random patterns against a frame-level brightness model.
module tb_led_trail_pwm;
  localparam int N        = 4;
  localparam int PWM_BITS = 8;
  localparam int PERIOD   = 1 << PWM_BITS;
  localparam int MAXLVL   = PERIOD - 1;
  localparam int STEP     = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  led_trail_pwm_if #(.N(N)) bus ();

  led_trail_pwm #(.N(N), .PWM_BITS(PWM_BITS), .DECAY_STEP(STEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int duty_of(input int lvl);
`ifdef LED_TRAIL_GAMMA_EN
    return (lvl * lvl) >> PWM_BITS;
`else
    return lvl;
`endif
  endfunction

  // One frame window: first sample is the frame_tick cycle, then pwm 0..254 of the new level.
  int hi_cnt[N];
  int tick_cnt;
  int tick_late;

  task automatic run_window(input logic [N-1:0] hold, input logic [N-1:0] pulse, input int pulse_k);
    for (int i = 0; i < N; i++) hi_cnt[i] = 0;
    tick_cnt  = 0;
    tick_late = 0;
    for (int k = 0; k < PERIOD; k++) begin
      bus.pat_in = (k == pulse_k) ? pulse : hold;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (bus.led_out[i]) hi_cnt[i]++;
      if (bus.frame_tick) begin
        tick_cnt++;
        if (k != 0) tick_late++;
      end
    end
  endtask

  typedef struct {
    logic [N-1:0] pat;
    int           lvl[N];
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] p, input int a, input int b, input int c, input int d);
    vec_t v;
    v.pat    = p;
    v.lvl[0] = a;
    v.lvl[1] = b;
    v.lvl[2] = c;
    v.lvl[3] = d;
    return v;
  endfunction

  // Frame-level reference: brightness only changes at frame starts, from what was seen last frame.
  int           m_e;
  int           m_lvl[N];
  logic [N-1:0] m_seen;

  task automatic model_step(input logic rst_v, input logic [N-1:0] pat_v);
    logic [N-1:0] exp_led;
    logic         exp_tick;
    int           pos;
    rst        = rst_v;
    bus.pat_in = pat_v;
    @(posedge clk);
    #1;
    exp_led  = '0;
    exp_tick = 1'b0;
    if (rst_v) begin
      m_e    = 0;
      m_seen = '0;
      for (int i = 0; i < N; i++) m_lvl[i] = 0;
    end else begin
      m_e++;
      pos = (m_e - 1) % PERIOD;
      for (int i = 0; i < N; i++) exp_led[i] = (pos < duty_of(m_lvl[i]));
      exp_tick = ((m_e % PERIOD) == 0);
      if ((m_e % PERIOD) == 0) begin
        for (int i = 0; i < N; i++) begin
          if (m_seen[i]) m_lvl[i] = MAXLVL;
          else m_lvl[i] = (m_lvl[i] > STEP) ? m_lvl[i] - STEP : 0;
        end
        m_seen = '0;
      end
      m_seen = m_seen | pat_v;
    end
    check("model_led", int'(bus.led_out), int'(exp_led));
    check("model_tick", int'(bus.frame_tick), int'(exp_tick));
  endtask

  vec_t tbl[14];
  int   decay_exp[10];

  initial begin
    int lit;
    int ticks;
    logic [N-1:0] rp;

    tbl[0]  = mk(4'b0001,   0,   0,   0,   0);
    tbl[1]  = mk(4'b0010, 255,   0,   0,   0);
    tbl[2]  = mk(4'b0100, 223, 255,   0,   0);
    tbl[3]  = mk(4'b1000, 191, 223, 255,   0);
    tbl[4]  = mk(4'b0000, 159, 191, 223, 255);
    tbl[5]  = mk(4'b0000, 127, 159, 191, 223);
    tbl[6]  = mk(4'b0101,  95, 127, 159, 191);
    tbl[7]  = mk(4'b0000, 255,  95, 255, 159);
    tbl[8]  = mk(4'b0000, 223,  63, 223, 127);
    tbl[9]  = mk(4'b0000, 191,  31, 191,  95);
    tbl[10] = mk(4'b0000, 159,   0, 159,  63);
    tbl[11] = mk(4'b0000, 127,   0, 127,  31);
    tbl[12] = mk(4'b1111,  95,   0,  95,   0);
    tbl[13] = mk(4'b0000, 255, 255, 255, 255);
    decay_exp = '{255, 223, 191, 159, 127, 95, 63, 31, 0, 0};

    bus.pat_in = '0;
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", int'(bus.led_out), 0);
    check("rst_tick", int'(bus.frame_tick), 0);
    rst = 1'b0;

    // Edges 1..255 after release: dark LEDs, no tick yet.
    lit   = 0;
    ticks = 0;
    for (int k = 1; k < PERIOD; k++) begin
      @(posedge clk);
      #1;
      if (bus.led_out != '0) lit++;
      if (bus.frame_tick) ticks++;
    end
    check("idle_led_cycles", lit, 0);
    check("first_tick_early", ticks, 0);

    // Single-cycle pulse on channel 1, then a plain fade.
    run_window('0, 4'b0010, 100);
    check("pulse_w0_tick", tick_cnt, 1);
    check("pulse_w0_ch1", hi_cnt[1], 0);
    for (int w = 0; w < 10; w++) begin
      run_window('0, '0, -1);
      check("decay_ch1", hi_cnt[1], duty_of(decay_exp[w]));
      check("decay_others", hi_cnt[0] + hi_cnt[2] + hi_cnt[3], 0);
      check("decay_tick", tick_cnt * 16 + tick_late, 16);
    end

    // Rotating and multi-bit patterns, one pattern per frame.
    for (int j = 0; j < 14; j++) begin
      run_window(tbl[j].pat, '0, -1);
      for (int i = 0; i < N; i++) check("table_ch", hi_cnt[i], duty_of(tbl[j].lvl[i]));
      check("table_tick", tick_cnt * 16 + tick_late, 16);
    end

    // Mid-frame reset with every channel bright.
    bus.pat_in = '0;
    repeat (50) @(posedge clk);
    #1;
    check("pre_rst_lit", int'(bus.led_out), 4'b1111);
    model_step(1'b1, '0);
    check("mid_rst_led", int'(bus.led_out), 0);
    check("mid_rst_tick", int'(bus.frame_tick), 0);

    for (int c = 0; c < 4000; c++) begin
      rp = '0;
      for (int i = 0; i < N; i++) if ($urandom_range(0, 299) == 0) rp[i] = 1'b1;
      if ($urandom_range(0, 49) == 0) rp = N'($urandom);
      model_step(($urandom_range(0, 1499) == 0), rp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
